// File: rtl/mmcm_drp_reconfig.sv
// mmcm_drp_reconfig
// Applies a queued batch of read-modify-write updates to MMCM DRP registers.
// The MMCM is held in reset for the whole batch. It is then released, and the
// block waits for LOCKED before it reports completion.
//
// Ports
//   clk_in1              sole clock (the DRP DCLK uses the same net)
//   reset                synchronous, active-high
//   wr_valid/wr_ready    queue-write handshake; wr_addr/wr_data/wr_mask give the entry
//                        (a mask bit of 1 keeps the current register bit)
//   commit               single-cycle request to run the queued batch
//   busy, done, err      status: done is a one-cycle pulse; err is 0 ok,
//                        1 drdy timeout, 2 lock timeout; err holds until the
//                        next accepted commit
//   mmcm_rst             MMCM RST
//   daddr/di/den/dwe     DRP request;  drp_do/drdy  DRP response
//   locked               MMCM LOCKED
//   dbg_state            current FSM state, for observation only
//
// Handshake: an entry transfers on a rising edge where wr_valid & wr_ready are
// both 1. wr_ready never depends on wr_valid. The source holds the entry
// stable until that edge.
module mmcm_drp_reconfig #(
  parameter int DEPTH        = 4,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic        clk_in1,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [6:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic [15:0] wr_mask,
  input  logic        commit,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic        mmcm_rst,
  output logic [6:0]  daddr,
  output logic [15:0] di,
  output logic        den,
  output logic        dwe,
  input  logic [15:0] drp_do,
  input  logic        drdy,
  input  logic        locked,
  output logic [3:0]  dbg_state
);

  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_MAX = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_ON, S_RD_REQ, S_RD_WAIT, S_WR_REQ,
    S_WR_WAIT, S_RELEASE, S_LOCK_WAIT, S_FINISH
  } state_t;

  state_t r_state, w_next_state;

  // Write queue
  logic [6:0]  r_q_addr [DEPTH];
  logic [15:0] r_q_data [DEPTH];
  logic [15:0] r_q_mask [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [PW:0]   r_count;

  logic [CW-1:0] r_cnt;
  logic [15:0]   r_rd_data;
  logic [6:0]    r_daddr_q;
  logic [15:0]   r_di_q;
  logic [1:0]    r_err;

  logic w_full, w_push, w_pop, w_drdy_to, w_lock_to, w_in_drp_wait;
  logic [6:0]  w_head_addr;
  logic [15:0] w_head_data, w_head_mask, w_wr_val;

  assign w_full      = (r_count == (PW+1)'(DEPTH));
  assign wr_ready    = !busy && !w_full;
  assign w_push      = wr_valid && wr_ready;
  assign w_pop       = (r_state == S_WR_WAIT) && drdy;
  assign w_head_addr = r_q_addr[r_rd_ptr];
  assign w_head_data = r_q_data[r_rd_ptr];
  assign w_head_mask = r_q_mask[r_rd_ptr];
  assign w_wr_val    = (r_rd_data & w_head_mask) | (w_head_data & ~w_head_mask);

  assign w_in_drp_wait = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
  assign w_drdy_to     = w_in_drp_wait && !drdy && (r_cnt == CW'(DRDY_TIMEOUT - 1));
  assign w_lock_to     = (r_state == S_LOCK_WAIT) && !locked &&
                         (r_cnt == CW'(LOCK_TIMEOUT - 1));
  assign err           = r_err;
  assign dbg_state     = r_state;

  // Queue storage. It has no reset because only the pointers define its contents.
  always_ff @(posedge clk_in1) begin
    if (w_push) begin
      r_q_addr[r_wr_ptr] <= wr_addr;
      r_q_data[r_wr_ptr] <= wr_data;
      r_q_mask[r_wr_ptr] <= wr_mask;
    end
  end

  // Queue pointers. A push happens only while idle and a pop only while busy,
  // so the two never occur in the same cycle.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_drdy_to) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else if (w_push) begin
      r_wr_ptr <= r_wr_ptr + PW'(1);
      r_count  <= r_count + (PW+1)'(1);
    end else if (w_pop) begin
      r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count  <= r_count - (PW+1)'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk_in1) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (commit) w_next_state = ((r_count != '0) || w_push) ? S_RST_ON : S_FINISH;
      S_RST_ON:    w_next_state = S_RD_REQ;
      S_RD_REQ:    w_next_state = S_RD_WAIT;
      S_RD_WAIT:   if (drdy) w_next_state = S_WR_REQ;
                   else if (w_drdy_to) w_next_state = S_RELEASE;
      S_WR_REQ:    w_next_state = S_WR_WAIT;
      S_WR_WAIT:   if (drdy) w_next_state = (r_count > (PW+1)'(1)) ? S_RD_REQ : S_RELEASE;
                   else if (w_drdy_to) w_next_state = S_RELEASE;
      S_RELEASE:   w_next_state = S_LOCK_WAIT;
      S_LOCK_WAIT: if (locked || w_lock_to) w_next_state = S_FINISH;
      S_FINISH:    w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (r_state != S_IDLE);
    done     = 1'b0;
    mmcm_rst = 1'b0;
    den      = 1'b0;
    dwe      = 1'b0;
    daddr    = r_daddr_q;
    di       = r_di_q;
    case (r_state)
      S_RST_ON, S_RD_WAIT, S_WR_WAIT: mmcm_rst = 1'b1;
      S_RD_REQ: begin
        mmcm_rst = 1'b1;
        den      = 1'b1;
        daddr    = w_head_addr;
      end
      S_WR_REQ: begin
        mmcm_rst = 1'b1;
        den      = 1'b1;
        dwe      = 1'b1;
        daddr    = w_head_addr;
        di       = w_wr_val;
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // Wait counter. It clears on every state change. The one exception is
  // RELEASE -> LOCK_WAIT: the lock timeout counts from the cycle the MMCM
  // reset is released, not from the first cycle of LOCK_WAIT.
  always_ff @(posedge clk_in1) begin
    if (reset) r_cnt <= '0;
    else if ((r_state != w_next_state) && (r_state != S_RELEASE)) r_cnt <= '0;
    else r_cnt <= r_cnt + CW'(1);
  end

  // Read capture, held copies of the DRP address/data, and error status
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      r_rd_data <= '0;
      r_daddr_q <= '0;
      r_di_q    <= '0;
      r_err     <= 2'd0;
    end else begin
      if ((r_state == S_RD_WAIT) && drdy) r_rd_data <= drp_do;
      if (den) r_daddr_q <= w_head_addr;
      if (r_state == S_WR_REQ) r_di_q <= w_wr_val;
      if ((r_state == S_IDLE) && commit) r_err <= 2'd0;
      else if (w_drdy_to) r_err <= 2'd1;
      else if (w_lock_to && (r_err != 2'd1)) r_err <= 2'd2;
    end
  end

endmodule
